// File: rtl/pipelined_dequantizer_if.sv
// pipelined_dequantizer_if
// Operand/result bundle for the pipelined dequantizer.
//   input_valid, input_tag, coefficient, step : operand side (driven by upstream)
//   output_valid, output_tag, product, saturated : result side (driven by the dequantizer)
// master modport: the upstream/downstream environment; slave modport: the dequantizer.
interface pipelined_dequantizer_if #(
  parameter int coef_width = 12,
  parameter int step_width = 8,
  parameter int out_width  = 16
);
  logic                         input_valid;
  logic [5:0]                   input_tag;
  logic signed [coef_width-1:0] coefficient;
  logic [step_width-1:0]        step;
  logic                         output_valid;
  logic [5:0]                   output_tag;
  logic signed [out_width-1:0]  product;
  logic                         saturated;

  modport master (
    output input_valid, input_tag, coefficient, step,
    input  output_valid, output_tag, product, saturated
  );

  modport slave (
    input  input_valid, input_tag, coefficient, step,
    output output_valid, output_tag, product, saturated
  );
endinterface

// File: rtl/pipelined_dequantizer.sv
// pipelined_dequantizer
// Signed coefficient times unsigned quantization step, computed by a shift-add
// pipeline with one stage per step bit, then sign restore and saturation.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high clear of every register
//   hold   : freezes every register (inputs not sampled) while high
//   bus    : slave side of pipelined_dequantizer_if (operands in, results out)
// Latency is step_width+1 unheld edges from operand capture to result.
module pipelined_dequantizer #(
  parameter int coef_width = 12,
  parameter int step_width = 8,
  parameter int out_width  = 16
) (
  input logic                     clock,
  input logic                     reset,
  input logic                     hold,
  pipelined_dequantizer_if.slave  bus
);

  localparam int acc_width  = coef_width + step_width;
  localparam int full_width = acc_width + 1;

  localparam logic [coef_width-1:0] mag_one = {{(coef_width-1){1'b0}}, 1'b1};
  localparam logic signed [full_width-1:0] pos_limit =
    {{(full_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
  localparam logic signed [full_width-1:0] neg_limit =
    {{(full_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

  // Stage 0 is index 0; stage i (1..step_width) is index i. mag/step are only
  // consumed by the stage after them, so the last stage does not keep them.
  logic [coef_width-1:0] mag_r   [0:step_width-1];
  logic [step_width-1:0] step_r  [0:step_width-1];
  logic [acc_width-1:0]  acc_r   [0:step_width];
  logic                  neg_r   [0:step_width];
  logic                  valid_r [0:step_width];
  logic [5:0]            tag_r   [0:step_width];

  logic                  out_valid_r;
  logic [5:0]            out_tag_r;
  logic [out_width-1:0]  out_product_r;
  logic                  out_saturated_r;

  logic                        in_neg;
  logic [coef_width-1:0]       in_mag;
  logic [full_width-1:0]       unsigned_acc;
  logic signed [full_width-1:0] signed_val;
  logic [out_width-1:0]        next_product;
  logic                        next_saturated;

  // Split the incoming coefficient into sign and magnitude; the most negative
  // value yields 2^(coef_width-1), which still fits the unsigned magnitude.
  always_comb begin
    in_neg = bus.coefficient[coef_width-1];
    if (in_neg) begin
      in_mag = ~bus.coefficient + mag_one;
    end else begin
      in_mag = bus.coefficient;
    end
  end

  // Restore the sign on the finished accumulator and clamp to the output range.
  always_comb begin
    unsigned_acc = {1'b0, acc_r[step_width]};
    if (neg_r[step_width]) begin
      signed_val = -$signed(unsigned_acc);
    end else begin
      signed_val = $signed(unsigned_acc);
    end
    if (signed_val > pos_limit) begin
      next_product   = pos_limit[out_width-1:0];
      next_saturated = 1'b1;
    end else if (signed_val < neg_limit) begin
      next_product   = neg_limit[out_width-1:0];
      next_saturated = 1'b1;
    end else begin
      next_product   = signed_val[out_width-1:0];
      next_saturated = 1'b0;
    end
  end

  // Pipeline registers: capture, shift-add stages and output, all frozen by hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < step_width; j++) begin
        mag_r[j]  <= {coef_width{1'b0}};
        step_r[j] <= {step_width{1'b0}};
      end
      for (int j = 0; j <= step_width; j++) begin
        acc_r[j]   <= {acc_width{1'b0}};
        neg_r[j]   <= 1'b0;
        valid_r[j] <= 1'b0;
        tag_r[j]   <= 6'd0;
      end
      out_valid_r     <= 1'b0;
      out_tag_r       <= 6'd0;
      out_product_r   <= {out_width{1'b0}};
      out_saturated_r <= 1'b0;
    end else if (!hold) begin
      mag_r[0]   <= in_mag;
      step_r[0]  <= bus.step;
      acc_r[0]   <= {acc_width{1'b0}};
      neg_r[0]   <= in_neg;
      valid_r[0] <= bus.input_valid;
      tag_r[0]   <= bus.input_tag;
      // Stage j adds the magnitude weighted by step bit j-1; the running sum is
      // bounded by mag*step, so acc_width bits never overflow.
      for (int j = 1; j <= step_width; j++) begin
        if (step_r[j-1][j-1]) begin
          acc_r[j] <= acc_r[j-1] + ({{step_width{1'b0}}, mag_r[j-1]} << (j-1));
        end else begin
          acc_r[j] <= acc_r[j-1];
        end
        neg_r[j]   <= neg_r[j-1];
        valid_r[j] <= valid_r[j-1];
        tag_r[j]   <= tag_r[j-1];
      end
      for (int j = 1; j < step_width; j++) begin
        mag_r[j]  <= mag_r[j-1];
        step_r[j] <= step_r[j-1];
      end
      out_valid_r     <= valid_r[step_width];
      out_tag_r       <= tag_r[step_width];
      out_product_r   <= next_product;
      out_saturated_r <= next_saturated;
    end
  end

  assign bus.output_valid = out_valid_r;
  assign bus.output_tag   = out_tag_r;
  assign bus.product      = out_product_r;
  assign bus.saturated    = out_saturated_r;

endmodule

// File: tb/tb_pipelined_dequantizer.sv
// tb_pipelined_dequantizer
// Directed and table-driven bench for pipelined_dequantizer (default widths).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_pipelined_dequantizer;

  logic clock = 1'b0;
  logic reset;
  logic hold;
  int   checks = 0;
  int   errors = 0;

  logic signed [11:0] sc [64];
  logic [7:0]         ss [64];

  pipelined_dequantizer_if #(.coef_width(12), .step_width(8), .out_width(16)) bus ();

  pipelined_dequantizer #(.coef_width(12), .step_width(8), .out_width(16)) dut (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  wire [23:0] obs = {bus.output_valid, bus.output_tag, bus.product, bus.saturated};

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [5:0] t, input logic signed [11:0] c,
                       input logic [7:0] s);
    bus.input_valid = v;
    bus.input_tag   = t;
    bus.coefficient = c;
    bus.step        = s;
  endtask

  // Reference: plain integer multiply then clamp; returns {saturated, product}.
  function automatic logic [16:0] ref_mul(input logic signed [11:0] c, input logic [7:0] s);
    int full;
    full = int'(c) * int'(s);
    if (full > 32767) return {1'b1, 16'h7FFF};
    else if (full < -32768) return {1'b1, 16'h8000};
    else return {1'b0, full[15:0]};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    hold  = 1'b0;
    drive(1'b0, 6'd0, 12'sd0, 8'd0);
    repeat (2) tick;
    checks++;
    if (bus.output_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.output_valid);
    end
    checks++;
    if (bus.output_tag !== 6'd0) begin
      errors++; $display("FAIL reset_tag: got %h expected 00", bus.output_tag);
    end
    checks++;
    if (bus.product !== 16'sd0) begin
      errors++; $display("FAIL reset_product: got %h expected 0000", bus.product);
    end
    checks++;
    if (bus.saturated !== 1'b0) begin
      errors++; $display("FAIL reset_saturated: got %b expected 0", bus.saturated);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency;
    drive(1'b1, 6'd3, -12'sd5, 8'd16);
    tick;
    drive(1'b0, 6'd0, 12'sd0, 8'd0);
    for (int n = 1; n <= 8; n++) begin
      tick;
      checks++;
      if (bus.output_valid !== 1'b0) begin
        errors++; $display("FAIL latency_early edge %0d: got valid %b expected 0", n, bus.output_valid);
      end
    end
    tick;
    checks++;
    if (obs !== {1'b1, 6'd3, -16'sd80, 1'b0}) begin
      errors++; $display("FAIL latency_result: got %h expected %h", obs, {1'b1, 6'd3, -16'sd80, 1'b0});
    end
    tick;
    checks++;
    if (bus.output_valid !== 1'b0) begin
      errors++; $display("FAIL latency_after: got valid %b expected 0", bus.output_valid);
    end
  endtask

  // One isolated operand; expected values are supplied by the caller.
  task automatic run_one(input string name, input logic signed [11:0] c, input logic [7:0] s,
                         input logic [5:0] t, input logic signed [15:0] exp_p, input logic exp_s);
    drive(1'b1, t, c, s);
    tick;
    drive(1'b0, 6'd0, 12'sd0, 8'd0);
    repeat (9) tick;
    checks++;
    if (obs !== {1'b1, t, exp_p, exp_s}) begin
      errors++; $display("FAIL %s: got %h expected %h", name, obs, {1'b1, t, exp_p, exp_s});
    end
  endtask

  task automatic test_saturation;
    run_one("neg_sat",    -12'sd2048, 8'd255, 6'd10, -16'sd32768, 1'b1);
    run_one("pos_sat",     12'sd2047, 8'd255, 6'd11,  16'sd32767, 1'b1);
    run_one("neg_exact",  -12'sd2048, 8'd16,  6'd12, -16'sd32768, 1'b0);
    run_one("minus_one",  -12'sd1,    8'd1,   6'd13, -16'sd1,     1'b0);
    run_one("pos_edge",    12'sd2047, 8'd16,  6'd14,  16'sd32752, 1'b0);
  endtask

  task automatic test_zeros;
    run_one("zero_coef",  12'sd0,  8'd200, 6'd20, 16'sd0, 1'b0);
    run_one("zero_step", -12'sd7,  8'd0,   6'd21, 16'sd0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [16:0] e;
    for (int i = 0; i < 64; i++) begin
      sc[i] = 12'($urandom_range(0, 4095));
      ss[i] = 8'($urandom_range(0, 255));
    end
    for (int c = 0; c < 64 + 9; c++) begin
      if (c < 64) drive(1'b1, 6'(c), sc[c], ss[c]);
      else drive(1'b0, 6'd0, 12'sd0, 8'd0);
      tick;
      if (c >= 9) begin
        e = ref_mul(sc[c-9], ss[c-9]);
        checks++;
        if (obs !== {1'b1, 6'(c-9), e[15:0], e[16]}) begin
          errors++; $display("FAIL stream idx %0d: got %h expected %h", c - 9, obs, {1'b1, 6'(c-9), e[15:0], e[16]});
        end
      end
    end
    drive(1'b0, 6'd0, 12'sd0, 8'd0);
    tick;
    checks++;
    if (bus.output_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: got valid %b expected 0", bus.output_valid);
    end
  endtask

  // Hold on edges 14..16: results 0..4 appear at edges 9..13, result 4 stays
  // frozen through the hold, results 5..19 follow at edges 17..31.
  task automatic test_hold;
    int idx;
    int j;
    logic [16:0] e;
    repeat (10) tick;
    for (int i = 0; i < 20; i++) begin
      sc[i] = 12'($urandom_range(0, 4095));
      ss[i] = 8'($urandom_range(1, 255));
    end
    idx = 0;
    for (int c = 0; c <= 34; c++) begin
      hold = (c >= 14 && c <= 16);
      if (idx < 20) drive(1'b1, 6'(idx), sc[idx], ss[idx]);
      else drive(1'b0, 6'd0, 12'sd0, 8'd0);
      tick;
      if (!hold && idx < 20) idx++;
      if (c >= 9 && c <= 13) j = c - 9;
      else if (c >= 14 && c <= 16) j = 4;
      else if (c >= 17 && c <= 31) j = c - 12;
      else j = -1;
      checks++;
      if (j >= 0) begin
        e = ref_mul(sc[j], ss[j]);
        if (obs !== {1'b1, 6'(j), e[15:0], e[16]}) begin
          errors++; $display("FAIL hold edge %0d: got %h expected %h", c, obs, {1'b1, 6'(j), e[15:0], e[16]});
        end
      end else if (bus.output_valid !== 1'b0) begin
        errors++; $display("FAIL hold_idle edge %0d: got valid %b expected 0", c, bus.output_valid);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_midstream;
    logic [16:0] e;
    repeat (10) tick;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 6'(40 + c), sc[c], ss[c]);
      tick;
    end
    drive(1'b0, 6'd0, 12'sd0, 8'd0);
    repeat (5) tick;
    e = ref_mul(sc[0], ss[0]);
    checks++;
    if (obs !== {1'b1, 6'd40, e[15:0], e[16]}) begin
      errors++; $display("FAIL midreset_pre: got %h expected %h", obs, {1'b1, 6'd40, e[15:0], e[16]});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 24'h000000) begin
      errors++; $display("FAIL midreset_async: got %h expected 000000", obs);
    end
    hold = 1'b1;
    drive(1'b1, 6'd50, 12'sd9, 8'd9);
    tick;
    checks++;
    if (obs !== 24'h000000) begin
      errors++; $display("FAIL midreset_hold: got %h expected 000000", obs);
    end
    reset = 1'b0;
    hold  = 1'b0;
    drive(1'b1, 6'd42, 12'sd100, 8'd3);
    tick;
    drive(1'b0, 6'd0, 12'sd0, 8'd0);
    for (int n = 1; n <= 8; n++) begin
      tick;
      checks++;
      if (bus.output_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_stale edge %0d: got valid %b expected 0", n, bus.output_valid);
      end
    end
    tick;
    checks++;
    if (obs !== {1'b1, 6'd42, 16'sd300, 1'b0}) begin
      errors++; $display("FAIL midreset_new: got %h expected %h", obs, {1'b1, 6'd42, 16'sd300, 1'b0});
    end
    tick;
    checks++;
    if (bus.output_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_after: got valid %b expected 0", bus.output_valid);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_saturation;
    test_zeros;
    test_back_to_back;
    test_hold;
    test_reset_midstream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_dequantizer.md
# pipelined_dequantizer

Pipelined signed-by-unsigned multiplier for the JPEG decode and reconstruction path. It multiplies a signed quantized coefficient by an unsigned quantization step, which is the inverse of the quantizing divider. The result is a saturated signed coefficient. A 6-bit tag and a valid bit travel alongside each operand so results can be re-associated with their block position downstream. A global `hold` input freezes the whole pipeline.

## Interface
Parameters:
- `coef_width`, 12: width of signed quantized coefficient input.
- `step_width`, 8: width of unsigned quantization step; also the number of partial-product stages.
- `out_width`, 16: width of signed saturated product output.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `hold`  in  1  pipeline freeze; when 1, no register changes and inputs are not sampled.
- `input_valid`  in  1  operand pair present this cycle.
- `input_tag`  in  6  opaque tag carried with the operands.
- `coefficient`  in  `coef_width`  signed two's-complement multiplicand.
- `step`  in  `step_width`  unsigned multiplier.
- `output_valid`  out  1  product on outputs is valid.
- `output_tag`  out  6  tag of the current product.
- `product`  out  `out_width`  signed saturated `coefficient*step`.
- `saturated`  out  1  the current product was clamped.

## Operation
- **Stage 0 (input register):**
  - Captures `neg = coefficient[MSB]`.
  - Captures `mag = |coefficient|` as an unsigned `coef_width`-bit value; −2^(coef_width−1) maps to 2^(coef_width−1) without overflow.
  - Captures `step`, `input_valid` and `input_tag`.
  - Clears the accumulator (width `coef_width+step_width`) to 0.
- **Stages 1..`step_width` (generate loop, stage i examines `step` bit i−1, LSB first):**
  - If the bit is 1: `acc += mag << (i−1)`; otherwise `acc` passes through unchanged.
  - `mag`, `step`, `neg`, valid and tag are forwarded unchanged.
  - No stage can overflow the accumulator.
- **Output stage:**
  - Signed value = `neg ? −acc : acc`, computed at width `coef_width+step_width+1`.
  - Clamped to [−2^(out_width−1), 2^(out_width−1)−1].
  - `saturated` = 1 iff clamping changed the value.
  - −2^(out_width−1) is reachable without saturation. Example: −2048×16 = −32768 with `saturated` = 0.
- **Valid qualification:**
  - Data registers update every unheld cycle, regardless of valid.
  - Only the valid and tag bits qualify a result.
  - Downstream ignores `product`, `output_tag` and `saturated` when `output_valid` = 0.
- **Zero cases:** `step` = 0 or `coefficient` = 0 gives `product` = 0 and `saturated` = 0, with no negative zero.
- **Ordering:** results emerge in input order. There is no reordering and no internal buffering beyond the pipeline registers.

## Timing
- **Latency:** operands sampled at unheld edge k appear on outputs after unheld edge k+`step_width`+1. With defaults, that is 9 edges.
- **Throughput:** one operand pair per unheld cycle, sustained indefinitely.
- **`hold` = 1 at an edge:**
  - Every stage, including stage 0 and the output registers, keeps its value.
  - `input_valid` is not sampled, so an operand presented during hold is dropped. Upstream re-presents it or keeps `input_valid` low.
  - Outputs remain stable and unchanged for the entire hold; an asserted `output_valid` stays asserted.
  - Releasing `hold` resumes exactly where the pipeline stopped. There is no loss or duplication.
- **Reset:**
  - While `reset` = 1, all stage valid bits are 0, `output_valid` = 0, `output_tag` = 0, `product` = 0 and `saturated` = 0. Data registers are also 0.
  - Reset asserted mid-stream discards all in-flight results. No stale result appears after release.
  - The first edge after deassertion samples inputs normally.
- **Reset and hold together:** `reset` takes priority over `hold`.

## Test plan
- **Basic latency:** `coefficient`=−5, `step`=16, tag 3, single valid → exactly 9 edges later `output_valid`=1, `product`=−80, tag 3, `saturated`=0; then `output_valid`=0.
- **Saturation and extremes:**
  - −2048×255 → −32768, `saturated`=1.
  - 2047×255 → 32767, `saturated`=1.
  - −2048×16 → −32768, `saturated`=0.
  - −1×1 → −1.
- **Zeros:** 0×200 → 0, and −7×0 → 0; both with `saturated`=0.
- **Streaming:** 64 back-to-back random pairs, tags 0..63 → 64 consecutive valid outputs in tag order, each matching a reference multiply with clamp.
- **Hold:** `hold` high for 3 cycles in the middle of a stream → output sequence identical except stretched by exactly 3 cycles; outputs frozen during hold; no drops or duplicates.
- **Reset mid-stream:** assert `reset` with 5 results in flight → `output_valid`=0 immediately and all outputs 0; after release, only newly issued operands produce valid outputs.
